// File: rtl/dct_mac_pkg.sv
// ---------------------------------------------------------------------------
// dct_mac_pkg : default widths, rounding constant and types for dct_mac_unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dct_mac_pkg;

  localparam int DATA_W_D = 8;
  localparam int COEF_W_D = 12;
  localparam int ACC_W_D  = 24;
  localparam int FRAC_D   = 10;
  localparam int OUT_W_D  = 12;
  localparam int TERMS_D  = 8;
  localparam int PROD_W_D = DATA_W_D + COEF_W_D;

  localparam logic [ACC_W_D-1:0] ROUND_C = ACC_W_D'(1) << (FRAC_D - 1);

  typedef logic signed [DATA_W_D-1:0] sample_t;
  typedef logic signed [COEF_W_D-1:0] coef_t;
  typedef logic signed [PROD_W_D-1:0] prod_t;
  typedef logic signed [ACC_W_D-1:0]  acc_t;
  typedef logic signed [OUT_W_D-1:0]  res_t;

  // The accumulator must hold TERMS full-width products without overflow.
  function automatic bit acc_w_ok(input int acc_w, input int data_w,
                                  input int coef_w, input int terms);
    return acc_w >= data_w + coef_w + $clog2(terms);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dct_mac_round.sv
// ---------------------------------------------------------------------------
// dct_mac_round : round-half-up, arithmetic shift by FRAC, width reduction.
// DCT_MAC_SAT_EN defined -> clamp to OUT_W range; undefined -> wrap.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dct_mac_round #(
  parameter int ACC_W = 24,
  parameter int FRAC  = 10,
  parameter int OUT_W = 12
) (
  input  logic [ACC_W-1:0] i_acc,
  output logic [OUT_W-1:0] o_res
);

  localparam logic [ACC_W-1:0] RND_C = ACC_W'(1) << (FRAC - 1);
  localparam int MAX_I = (1 << (OUT_W - 1)) - 1;
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(MAX_I);
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-MAX_I - 1);

  logic [ACC_W-1:0]        w_sum;
  logic signed [ACC_W-1:0] w_shift;
  logic signed [ACC_W-1:0] w_pick;
  logic                    w_unused;

  assign w_sum   = i_acc + RND_C;
  assign w_shift = $signed(w_sum) >>> FRAC;

`ifdef DCT_MAC_SAT_EN
  always_comb begin
    w_pick = w_shift;
    if (w_shift > MAX_V)      w_pick = MAX_V;
    else if (w_shift < MIN_V) w_pick = MIN_V;
  end
`else
  assign w_pick = w_shift;
`endif

  // Wrap mode simply drops the upper bits; in clamp mode they equal the sign.
  assign o_res    = w_pick[OUT_W-1:0];
  assign w_unused = ^w_pick[ACC_W-1:OUT_W];

endmodule

`default_nettype wire

// File: rtl/dct_mac_unit.sv
// ---------------------------------------------------------------------------
// dct_mac_unit : 4-stage signed MAC producing one rounded DCT term per
// TERMS input pairs. Output rounding/saturation lives in dct_mac_round.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dct_mac_unit
  import dct_mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int COEF_W = COEF_W_D,
  parameter int ACC_W  = ACC_W_D,
  parameter int FRAC   = FRAC_D,
  parameter int OUT_W  = OUT_W_D,
  parameter int TERMS  = TERMS_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] din,
  input  logic [COEF_W-1:0] coef,
  output logic [OUT_W-1:0]  dout,
  output logic              out_valid
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int CNT_W  = (TERMS > 1) ? $clog2(TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TERMS - 1);

  if (!acc_w_ok(ACC_W, DATA_W, COEF_W, TERMS)) begin : g_acc_w_check
    $error("dct_mac_unit: ACC_W too small for DATA_W+COEF_W+clog2(TERMS)");
  end

  logic [CNT_W-1:0]         r_cnt;
  logic signed [DATA_W-1:0] r_s0_din;
  logic signed [COEF_W-1:0] r_s0_coef;
  logic                     r_s0_valid, r_s0_first, r_s0_last;
  logic signed [PROD_W-1:0] r_s1_prod;
  logic                     r_s1_valid, r_s1_first, r_s1_last;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_s2_last;

  logic                     w_first, w_last;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic [OUT_W-1:0]         w_res;

  assign w_first    = (r_cnt == '0);
  assign w_last     = (r_cnt == LAST_C);
  assign w_prod_ext = ACC_W'(r_s1_prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_s0_din   <= '0;
      r_s0_coef  <= '0;
      r_s0_valid <= 1'b0;
      r_s0_first <= 1'b0;
      r_s0_last  <= 1'b0;
      r_s1_prod  <= '0;
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_acc      <= '0;
      r_s2_last  <= 1'b0;
    end else if (ena) begin
      if (clr) begin
        r_cnt      <= '0;
        r_s0_valid <= 1'b0;
        r_s0_first <= 1'b0;
        r_s0_last  <= 1'b0;
        r_s1_valid <= 1'b0;
        r_s1_first <= 1'b0;
        r_s1_last  <= 1'b0;
        r_s2_last  <= 1'b0;
      end else begin
        r_s0_valid <= in_valid;
        r_s0_first <= in_valid & w_first;
        r_s0_last  <= in_valid & w_last;
        if (in_valid) begin
          r_s0_din  <= din;
          r_s0_coef <= coef;
          r_cnt     <= w_last ? '0 : r_cnt + CNT_W'(1);
        end

        r_s1_prod  <= r_s0_din * r_s0_coef;
        r_s1_valid <= r_s0_valid;
        r_s1_first <= r_s0_first;
        r_s1_last  <= r_s0_last;

        // Loading on the first term keeps consecutive vectors independent.
        if (r_s1_valid) r_acc <= r_s1_first ? w_prod_ext : r_acc + w_prod_ext;
        r_s2_last <= r_s1_valid & r_s1_last;
      end
    end
  end

  // Output stage ignores clr so a finished sum is never dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout      <= '0;
      out_valid <= 1'b0;
    end else if (ena) begin
      out_valid <= r_s2_last;
      if (r_s2_last) dout <= w_res;
    end
  end

  dct_mac_round #(
    .ACC_W (ACC_W),
    .FRAC  (FRAC),
    .OUT_W (OUT_W)
  ) u_round (
    .i_acc (r_acc),
    .o_res (w_res)
  );

endmodule

`default_nettype wire

// File: tb/tb_dct_mac_unit.sv
// ---------------------------------------------------------------------------
// tb_dct_mac_unit : randomized self-checking bench with arithmetic reference.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dct_mac_unit;

  localparam int DATA_W = 8;
  localparam int COEF_W = 12;
  localparam int FRAC   = 10;
  localparam int OUT_W  = 12;
  localparam int TERMS  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b1;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic [COEF_W-1:0] coef = '0;
  logic signed [OUT_W-1:0] dout;
  logic out_valid;

  int total = 0;
  int bad = 0;

  int g_din[$];
  int g_coef[$];
  int g_val[$];
  int g_ecyc[$];
  int g_last[$];

  dct_mac_unit dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .clr       (clr),
    .in_valid  (in_valid),
    .din       (din),
    .coef      (coef),
    .dout      (dout),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_out(input longint sum);
    longint r;
    logic signed [OUT_W-1:0] lo;
    r = (sum + (longint'(1) << (FRAC - 1))) >>> FRAC;
`ifdef DCT_MAC_SAT_EN
    if (r > longint'((1 << (OUT_W - 1)) - 1)) r = longint'((1 << (OUT_W - 1)) - 1);
    if (r < -longint'(1 << (OUT_W - 1)))      r = -longint'(1 << (OUT_W - 1));
`endif
    lo = r[OUT_W-1:0];
    return int'(lo);
  endfunction

  function automatic int model_vec(input int base);
    longint s = 0;
    for (int i = 0; i < TERMS; i++) s += longint'(g_din[base+i]) * longint'(g_coef[base+i]);
    return model_out(s);
  endfunction

  task automatic load_const(input int n, input int d, input int c);
    for (int i = 0; i < n; i++) begin
      g_din.push_back(d);
      g_coef.push_back(c);
    end
  endtask

  // Drives g_din/g_coef with random gaps and freezes; records strobes by enabled-edge index.
  task automatic run_stream(input int gap_pct, input int freeze_pct);
    int idx, ecnt, drain, guard;
    bit en, vld;
    idx = 0; ecnt = 0; drain = 6; guard = 0;
    g_val.delete(); g_ecyc.delete(); g_last.delete();
    while ((idx < g_din.size() || drain > 0) && guard < 4000) begin
      en  = ($urandom_range(0, 99) >= freeze_pct);
      vld = (idx < g_din.size()) && ($urandom_range(0, 99) >= gap_pct);
      ena = en;
      in_valid = vld;
      din  = vld ? DATA_W'(g_din[idx])  : DATA_W'($urandom);
      coef = vld ? COEF_W'(g_coef[idx]) : COEF_W'($urandom);
      step();
      guard++;
      if (en) begin
        ecnt++;
        if (vld) begin
          if (idx % TERMS == TERMS - 1) g_last.push_back(ecnt);
          idx++;
        end
        if (out_valid) begin
          g_val.push_back(int'(dout));
          g_ecyc.push_back(ecnt);
        end
        if (idx >= g_din.size()) drain--;
      end
    end
    ena = 1'b1;
    in_valid = 1'b0;
    if (guard >= 4000) begin
      total++; bad++;
      $display("FAIL stream_timeout: got %0d cycles, need < 4000", guard);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total++;
    if (dout !== '0) begin bad++; $display("FAIL reset_dout: got %0d need 0", dout); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b need 0", out_valid); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    for (int i = 0; i < TERMS; i++) begin
      in_valid = 1'b1; din = DATA_W'(1); coef = COEF_W'(1024);
      step();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early: got %b need 0 at term %0d", out_valid, i); end
    end
    in_valid = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      step();
      total++;
      if (out_valid !== (k == 4)) begin
        bad++; $display("FAIL basic_latency: edge %0d got %b need %b", k, out_valid, (k == 4));
      end
    end
    total++;
    if (int'(dout) !== 8) begin bad++; $display("FAIL basic_dout: got %0d need 8", dout); end
    ena = 1'b0;
    step(); step();
    total++;
    if (out_valid !== 1'b1 || int'(dout) !== 8) begin
      bad++; $display("FAIL freeze_hold: got valid=%b dout=%0d need 1/8", out_valid, dout);
    end
    ena = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b0 || int'(dout) !== 8) begin
      bad++; $display("FAIL strobe_width: got valid=%b dout=%0d need 0/8", out_valid, dout);
    end
  endtask

  task automatic test_rounding();
    g_din.delete(); g_coef.delete();
    load_const(TERMS, 1, 64);
    load_const(TERMS, 1, 63);
    run_stream(0, 0);
    total++;
    if (g_val.size() !== 2) begin bad++; $display("FAIL round_count: got %0d need 2", g_val.size()); end
    for (int v = 0; v < 2 && v < g_val.size(); v++) begin
      total++;
      if (g_val[v] !== model_vec(v * TERMS)) begin
        bad++; $display("FAIL round_val%0d: got %0d need %0d", v, g_val[v], model_vec(v * TERMS));
      end
    end
  endtask

  task automatic test_extreme();
    g_din.delete(); g_coef.delete();
    load_const(TERMS, -128, -2048);
    run_stream(0, 0);
    total++;
    if (g_val.size() !== 1 || g_val[0] !== model_vec(0)) begin
      bad++; $display("FAIL extreme: got n=%0d val=%0d need 1/%0d", g_val.size(),
                      (g_val.size() > 0) ? g_val[0] : 0, model_vec(0));
    end
  endtask

  task automatic test_back_to_back();
    g_din.delete(); g_coef.delete();
    load_const(TERMS, 2, 1024);
    load_const(TERMS, -3, 1024);
    run_stream(0, 0);
    total++;
    if (g_val.size() !== 2) begin
      bad++; $display("FAIL b2b_count: got %0d need 2", g_val.size());
    end else begin
      total++;
      if (g_val[0] !== model_vec(0)) begin bad++; $display("FAIL b2b_first: got %0d need %0d", g_val[0], model_vec(0)); end
      total++;
      if (g_val[1] !== model_vec(TERMS)) begin bad++; $display("FAIL b2b_second: got %0d need %0d", g_val[1], model_vec(TERMS)); end
      total++;
      if (g_ecyc[1] - g_ecyc[0] !== TERMS) begin
        bad++; $display("FAIL b2b_spacing: got %0d need %0d", g_ecyc[1] - g_ecyc[0], TERMS);
      end
    end
  endtask

  task automatic check_stream(input string name, input int nvec);
    total++;
    if (g_val.size() !== nvec) begin
      bad++; $display("FAIL %s_count: got %0d need %0d", name, g_val.size(), nvec);
    end
    for (int v = 0; v < nvec && v < g_val.size() && v < g_last.size(); v++) begin
      total++;
      if (g_val[v] !== model_vec(v * TERMS)) begin
        bad++; $display("FAIL %s_val%0d: got %0d need %0d", name, v, g_val[v], model_vec(v * TERMS));
      end
      total++;
      if (g_ecyc[v] - g_last[v] !== 3) begin
        bad++; $display("FAIL %s_lat%0d: got %0d need 3", name, v, g_ecyc[v] - g_last[v]);
      end
    end
  endtask

  task automatic test_gaps_ena();
    g_din.delete(); g_coef.delete();
    load_const(TERMS, 5, 512);
    run_stream(30, 25);
    check_stream("gaps", 1);
  endtask

  task automatic test_random();
    g_din.delete(); g_coef.delete();
    for (int i = 0; i < 6 * TERMS; i++) begin
      g_din.push_back($urandom_range(0, 255) - 128);
      g_coef.push_back($urandom_range(0, 4095) - 2048);
    end
    run_stream(25, 15);
    check_stream("rand", 6);
  endtask

  task automatic test_clr();
    int prev;
    prev = int'(dout);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; din = DATA_W'(7); coef = COEF_W'(1000);
      step();
    end
    clr = 1'b1; din = DATA_W'(9); coef = COEF_W'(999);
    step();
    clr = 1'b0; in_valid = 1'b0;
    total++;
    if (int'(dout) !== prev) begin bad++; $display("FAIL clr_dout_kept: got %0d need %0d", dout, prev); end
    g_din.delete(); g_coef.delete();
    load_const(TERMS, 1, 1024);
    run_stream(0, 0);
    total++;
    if (g_val.size() !== 1 || g_val[0] !== model_vec(0)) begin
      bad++; $display("FAIL clr_restart: got n=%0d val=%0d need 1/%0d", g_val.size(),
                      (g_val.size() > 0) ? g_val[0] : 0, model_vec(0));
    end
  endtask

  task automatic test_clr_s3();
    for (int i = 0; i < TERMS; i++) begin
      in_valid = 1'b1; din = DATA_W'(3); coef = COEF_W'(1024);
      step();
    end
    in_valid = 1'b0;
    step(); step(); step();
    total++;
    if (out_valid !== 1'b1 || int'(dout) !== 24) begin
      bad++; $display("FAIL s3_strobe: got valid=%b dout=%0d need 1/24", out_valid, dout);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    total++;
    if (int'(dout) !== 24 || out_valid !== 1'b0) begin
      bad++; $display("FAIL s3_clr_keep: got valid=%b dout=%0d need 0/24", out_valid, dout);
    end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; din = DATA_W'(1); coef = COEF_W'(1024);
      step();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (dout !== '0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_async: got valid=%b dout=%0d need 0/0", out_valid, dout);
    end
    step();
    rst = 1'b0;
    step();
    g_din.delete(); g_coef.delete();
    load_const(TERMS, 1, 1024);
    run_stream(0, 0);
    total++;
    if (g_val.size() !== 1 || g_val[0] !== 8) begin
      bad++; $display("FAIL rst_restart: got n=%0d val=%0d need 1/8", g_val.size(),
                      (g_val.size() > 0) ? g_val[0] : 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_extreme();
    test_back_to_back();
    test_gaps_ena();
    test_random();
    test_clr();
    test_clr_s3();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dct_mac_unit.md
# dct_mac_unit

Pipelined signed multiply-accumulate stage for the row/column 1-D DCT units inside `fdct_zigzag.dct_mod`. Consumes a stream of (sample, coefficient) pairs, registers each product, and accumulates `TERMS` products per output. Emits one rounded, width-reduced DCT term per vector, with a single-cycle valid strobe. Feeds the DCT block's output/transpose registers.

## Interface
- `DATA_W`, default 8: signed, level-shifted pixel/intermediate width.
- `COEF_W`, default 12: signed cosine coefficient width.
- `ACC_W`, default 24: accumulator width; must be ≥ `DATA_W+COEF_W+clog2(TERMS)`.
- `FRAC`, default 10: coefficient fraction bits removed at output.
- `OUT_W`, default 12: signed result width.
- `TERMS`, default 8: products per output.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `ena`, in, 1: clock enable; low freezes all state.
- `clr`, in, 1: synchronous abort of current vector and pipeline.
- `in_valid`, in, 1: `din`/`coef` pair present.
- `din`, in, `DATA_W`: signed sample.
- `coef`, in, `COEF_W`: signed coefficient.
- `dout`, out, `OUT_W`: signed rounded result; reset 0.
- `out_valid`, out, 1: one-cycle strobe; reset 0.

## Operation
- Pipeline stages, all gated by `ena`:
  - S0 registers `din`, `coef`, valid, and the `first`/`last` tags.
  - S1 forms `mult_res = din*coef` at full `DATA_W+COEF_W` width, sign-extended.
  - S2 accumulates. On `first` it loads `mult_res`; otherwise it adds.
  - S3 runs on `last`: add `1<<(FRAC-1)`, arithmetic shift right by `FRAC`, reduce to `OUT_W`, register `dout`, pulse `out_valid`.
- Term counter runs 0..`TERMS-1` and advances only on accepted `in_valid`.
  - Count 0 tags `first`; count `TERMS-1` tags `last` and wraps to 0.
- Idle cycles (`in_valid` low) between terms are allowed. The accumulator holds and the counter holds.
- Back-to-back vectors run with no bubble. The load-on-`first` rule isolates consecutive sums.
- `dout` holds its last value between strobes.
- `clr` resets the counter to 0 and clears valid/tags in S0–S2. It does not change `dout`.
  - `clr` together with `in_valid`: the input is discarded, and the next accepted pair is term 0.
  - `clr` does not cancel a result already latched into S3.
- `ena` low: no register updates, including the counter, valid pipeline, and `out_valid` (strobe is held). `clr` is ignored while `ena` is low.
- `rst` mid-vector: all state and outputs go to 0 immediately; the partial sum is lost.
- Accumulation wraps modulo 2^`ACC_W`. Width parameters guarantee no overflow for legal inputs.

## Timing
- Latency is 4 `ena` edges from sampling term `TERMS-1` to `out_valid` high.
- Throughput is one pair per cycle and one result per `TERMS` cycles.
- `out_valid` is high for exactly one enabled cycle.
- No backpressure. The consumer must accept every strobe.

## Configuration
- `DCT_MAC_SAT_EN` defined: the shifted result clamps to [−2^(`OUT_W`−1), 2^(`OUT_W`−1)−1].
- `DCT_MAC_SAT_EN` undefined: the result is truncated to the low `OUT_W` bits (two's-complement wrap).

## Structure
- Package `dct_mac_pkg` holds:
  - default width constants;
  - `ROUND_C = 1<<(FRAC-1)`;
  - typedefs `sample_t`, `coef_t`, `prod_t`, `acc_t`, `res_t`;
  - the `ACC_W` legality check function.
- Sub-module `dct_mac_round` holds the S3 combinational round/shift and the saturate-or-wrap logic. It is the only place `DCT_MAC_SAT_EN` is tested.

## Test plan
- 8× (`din`=1, `coef`=1024) with `in_valid` held high → `out_valid` 4 cycles after the 8th pair, `dout`=8.
- Rounding:
  - 8× (1, 64) → `dout`=1 (512 rounds up).
  - 8× (1, 63) → `dout`=0.
- 8× (−128, −2048):
  - with `DCT_MAC_SAT_EN` → `dout`=2047;
  - without → `dout`=−2048.
- Two vectors back-to-back, 8× (2, 1024) then 8× (−3, 1024) → strobes 8 cycles apart, `dout`=16 then −24; no carry-over.
- `in_valid` gaps and `ena` low for 3 cycles mid-vector, 8× (5, 512) → `dout`=20 and latency stretched by the frozen cycles. Then `clr` after 4 terms followed by 8× (1, 1024) → single strobe, `dout`=8.
- `rst` asserted after 5 terms → `dout`=0 and `out_valid`=0 immediately. After release, 8× (1, 1024) → `dout`=8.
